ahblite_waterlight_gen: RTL and testbench
=========================================

// Module: ahblite_waterlight_gen
// PURPOSE
//  AHB-Lite slave that drives a LED_W-wide running-light pattern on a programmable tick.
//  Registers set mode, enable, tick period and seed pattern. Integrated tick counter and
//  pattern engine drive the LED pins directly.
//  Sits on the AHB-Lite bus matrix as a zero-wait-state peripheral.
// PARAMETERS
//  LED_W     8   number of LED outputs (2..32)
//  SPEED_W   32  width of tick-period register/counter (1..32)
//  RST_SEED  1   reset value of LED pattern (LED_W bits)
// PORTS
//  HCLK        in   1        bus clock; all logic on rising edge
//  HRESETn     in   1        asynchronous active-low reset
//  HSEL        in   1        slave select
//  HADDR       in   32       address; HADDR[3:2] selects register
//  HTRANS      in   2        transfer type; HTRANS[1]=1 is NONSEQ/SEQ
//  HSIZE       in   3        ignored; all accesses treated as word
//  HPROT       in   4        ignored
//  HWRITE      in   1        1=write
//  HWDATA      in   32       write data (data phase)
//  HREADY      in   1        bus ready
//  HREADYOUT   out  1        constant 1
//  HRDATA      out  32       read data
//  HRESP       out  1        constant 0 (OKAY)
//  led         out  LED_W    current LED pattern
//  tick        out  1        1-cycle pulse on each pattern step
// BEHAVIOUR
//  Register map (HADDR[3:2]):
//   0 CTRL  RW  [1:0] mode: 0 off, 1 rotate-left, 2 rotate-right, 3 blink (invert); [8] enable; rest read 0
//   1 SPEED RW  [SPEED_W-1:0] period; tick every SPEED+1 cycles
//   2 SEED  WO  write loads led <= HWDATA[LED_W-1:0]; reads return current led
//   3 STAT  RO  [SPEED_W-1:0] current counter value; writes ignored
//  Bus:
//   - Address phase valid = HSEL & HTRANS[1] & HREADY.
//   - On valid, register HADDR[3:2] and HWRITE.
//   - Write commits at end of the following cycle from HWDATA.
//   - Reads: HRDATA combinational from registered index, live values, no wait states.
//  Reset: CTRL=0, SPEED=0, counter=0, led=RST_SEED, tick=0, pipeline regs cleared.
//  Tick counter cnt:
//   - Disabled (CTRL[8]=0): cnt forced to 0, tick=0, led holds.
//   - Enabled: if cnt==SPEED then tick=1 next cycle and cnt<=0; else cnt<=cnt+1.
//   - SPEED=0 gives a tick every cycle.
//   - Data-phase write to CTRL or SPEED clears cnt to 0 that cycle; no tick that cycle.
//  Pattern update on tick (registered with tick):
//   mode0 led<=0; mode1 {led[LED_W-2:0],led[LED_W-1]}; mode2 {led[0],led[LED_W-1:1]}; mode3 ~led.
//  Collisions:
//   - SEED write in the same cycle as a tick: SEED wins; tick pulse still asserts.
//   - SPEED lowered below current cnt: cleared by write rule, so no wrap past 2^SPEED_W.
//   - Back-to-back writes (pipelined address/data) fully supported.
//   - Async reset mid-sequence returns all state to reset values immediately.
// TESTING
//  1 Reset: HRESETn low -> led=RST_SEED, tick=0, reads of CTRL/SPEED return 0.
//  2 SPEED=3, CTRL=0x101 -> tick every 4 cycles; led 01->02->04->...->80->01 (LED_W=8).
//  3 CTRL=0x102, SEED=0x81 -> led 81,C0,60,30 on successive ticks;
//    SEED write colliding with tick -> led=SEED value.
//  4 CTRL=0x103, SPEED=0 -> led toggles 01/FE every cycle, tick held high.
//  5 Back-to-back writes CTRL then SPEED then read STAT -> each register correct,
//    cnt restarts from 0 after SPEED write.
//  6 Enable cleared mid-count -> cnt=0, led frozen;
//    re-enable -> first tick after SPEED+1 cycles.

Source files
------------

// File: rtl/ahblite_waterlight_gen.sv
// ---------------------------------------------------------------------------
// ahblite_waterlight_gen
//   Zero-wait-state AHB-Lite slave that drives a running-light pattern onto
//   LED_W output pins. A programmable down-the-bus tick period advances the
//   pattern by one step per tick (rotate left, rotate right, invert or clear).
//
//   Register map (HADDR[3:2]):
//     0 CTRL  RW  [1:0] mode (0 off, 1 rol, 2 ror, 3 blink), [8] enable
//     1 SPEED RW  tick period; one tick every SPEED+1 cycles
//     2 SEED  WO  loads the LED pattern; reads return the live pattern
//     3 STAT  RO  live tick-counter value
//
// Ports
//   HCLK, HRESETn          bus clock, async active-low reset
//   HSEL, HADDR, HTRANS,
//   HSIZE, HPROT, HWRITE,
//   HWDATA, HREADY         AHB-Lite slave inputs (HSIZE/HPROT ignored)
//   HREADYOUT, HRDATA,
//   HRESP                  AHB-Lite slave outputs (always ready, always OKAY)
//   led                    current LED pattern
//   tick                   one-cycle pulse on every pattern step
// ---------------------------------------------------------------------------
module ahblite_waterlight_gen #(
    parameter int unsigned LED_W    = 8,
    parameter int unsigned SPEED_W  = 32,
    parameter int unsigned RST_SEED = 1
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HSIZE,
    input  logic [3:0]         HPROT,
    input  logic               HWRITE,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic               HREADYOUT,
    output logic [31:0]        HRDATA,
    output logic               HRESP,
    output logic [LED_W-1:0]   led,
    output logic               tick
);

    localparam logic [1:0] A_CTRL  = 2'd0;
    localparam logic [1:0] A_SPEED = 2'd1;
    localparam logic [1:0] A_SEED  = 2'd2;
    localparam logic [1:0] A_STAT  = 2'd3;

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ROL   = 2'd1;
    localparam logic [1:0] M_ROR   = 2'd2;
    localparam logic [1:0] M_BLINK = 2'd3;

    logic               w_addr_valid;
    logic               r_dp_valid;
    logic               r_dp_write;
    logic [1:0]         r_dp_idx;

    logic [1:0]         r_mode;
    logic               r_en;
    logic [SPEED_W-1:0] r_speed;
    logic [SPEED_W-1:0] r_cnt;
    logic [LED_W-1:0]   r_led;
    logic               r_tick;

    logic               w_wr;
    logic               w_wr_ctrl;
    logic               w_wr_speed;
    logic               w_wr_seed;
    logic               w_restart;
    logic               w_at_term;
    logic               w_fire;
    logic [LED_W-1:0]   w_led_step;
    logic               w_unused;

    assign w_unused = ^{HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};

    // Address phase capture. When HREADY is low another slave is stalling the
    // bus, so the pending data-phase state must be held, not overwritten.
    assign w_addr_valid = HSEL & HTRANS[1] & HREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_idx   <= 2'd0;
        end else if (HREADY) begin
            r_dp_valid <= w_addr_valid;
            if (w_addr_valid) begin
                r_dp_write <= HWRITE;
                r_dp_idx   <= HADDR[3:2];
            end
        end
    end

    assign w_wr       = r_dp_valid & r_dp_write;
    assign w_wr_ctrl  = w_wr & (r_dp_idx == A_CTRL);
    assign w_wr_speed = w_wr & (r_dp_idx == A_SPEED);
    assign w_wr_seed  = w_wr & (r_dp_idx == A_SEED);

    // Any timing reconfiguration restarts the period from zero; this is also
    // what keeps the counter from running past a freshly lowered SPEED.
    assign w_restart = w_wr_ctrl | w_wr_speed;
    assign w_at_term = (r_cnt == r_speed);
    assign w_fire    = r_en & w_at_term & ~w_restart;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_mode  <= M_OFF;
            r_en    <= 1'b0;
            r_speed <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_mode <= HWDATA[1:0];
                r_en   <= HWDATA[8];
            end
            if (w_wr_speed) begin
                r_speed <= HWDATA[SPEED_W-1:0];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_fire;
            if (!r_en || w_restart || w_at_term) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + SPEED_W'(1);
            end
        end
    end

    always_comb begin
        w_led_step = r_led;
        case (r_mode)
            M_OFF:   w_led_step = '0;
            M_ROL:   w_led_step = {r_led[LED_W-2:0], r_led[LED_W-1]};
            M_ROR:   w_led_step = {r_led[0], r_led[LED_W-1:1]};
            M_BLINK: w_led_step = ~r_led;
            default: w_led_step = r_led;
        endcase
    end

    // A SEED write beats a simultaneous step; the tick pulse is unaffected.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_led <= LED_W'(RST_SEED);
        end else if (w_wr_seed) begin
            r_led <= HWDATA[LED_W-1:0];
        end else if (w_fire) begin
            r_led <= w_led_step;
        end
    end

    always_comb begin
        HRDATA = '0;
        case (r_dp_idx)
            A_CTRL:  HRDATA = {23'd0, r_en, 6'd0, r_mode};
            A_SPEED: HRDATA = 32'(r_speed);
            A_SEED:  HRDATA = 32'(r_led);
            A_STAT:  HRDATA = 32'(r_cnt);
            default: HRDATA = '0;
        endcase
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign led       = r_led;
    assign tick      = r_tick;

endmodule

// File: tb/tb_ahblite_waterlight_gen.sv
module tb_ahblite_waterlight_gen;

    localparam int unsigned LED_W = 8;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [LED_W-1:0] led;
    logic        tick;

    ahblite_waterlight_gen #(.LED_W(LED_W), .SPEED_W(32), .RST_SEED(1)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .led(led), .tick(tick)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [7:0]  led;
        logic        tick;
        bit          rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: register contents plus "position within the period".
    logic [1:0]        m_mode;
    bit                m_en;
    longint unsigned   m_speed;
    longint unsigned   m_pos;
    logic [7:0]        m_led;
    bit                m_tick;

    // Transfer currently in its data phase.
    bit          dp_valid;
    bit          dp_write;
    logic [1:0]  dp_idx;
    logic [31:0] dp_wdata;

    function automatic void model_reset();
        m_mode  = 2'd0;
        m_en    = 1'b0;
        m_speed = 0;
        m_pos   = 0;
        m_led   = 8'h01;
        m_tick  = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] idx);
        case (idx)
            2'd0:    return (32'(m_en) << 8) | 32'(m_mode);
            2'd1:    return 32'(m_speed);
            2'd2:    return 32'(m_led);
            default: return 32'(m_pos);
        endcase
    endfunction

    function automatic logic [7:0] pattern_step(input logic [1:0] mode, input logic [7:0] cur);
        int unsigned v;
        v = cur;
        case (mode)
            2'd0:    v = 0;
            2'd1:    v = ((v << 1) | (v >> 7)) & 32'hFF;
            2'd2:    v = ((v >> 1) | (v << 7)) & 32'hFF;
            default: v = (~v) & 32'hFF;
        endcase
        return v[7:0];
    endfunction

    // Advance the model across one clock edge, given the data-phase transfer.
    function automatic void model_advance();
        bit wr, restart, fire;
        wr      = dp_valid && dp_write;
        restart = wr && (dp_idx == 2'd0 || dp_idx == 2'd1);
        fire    = 1'b0;
        if (!m_en || restart) begin
            m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % (m_speed + 1);
            fire  = (m_pos == 0);
        end
        if (wr && dp_idx == 2'd2)  m_led = dp_wdata[7:0];
        else if (fire)             m_led = pattern_step(m_mode, m_led);
        if (wr && dp_idx == 2'd0) begin
            m_mode = dp_wdata[1:0];
            m_en   = dp_wdata[8];
        end
        if (wr && dp_idx == 2'd1)  m_speed = longint'(dp_wdata);
        m_tick = fire;
    endfunction

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HREADY = 1'b1;
        HADDR  = 32'd0;
        HWDATA = 32'd0;
    endtask

    // One bus cycle: present a new address phase (or bus noise that must not
    // start a transfer) plus write data for the transfer already in data phase.
    task automatic step(input bit v, input bit w, input logic [1:0] idx, input logic [31:0] wd);
        exp_t e;
        int   n;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        HWDATA  = (dp_valid && dp_write) ? dp_wdata : $urandom();
        HADDR   = ($urandom() & 32'hFFFF_FFF0) | {28'd0, idx, 2'b00};
        HREADY  = 1'b1;
        if (v) begin
            HSEL   = 1'b1;
            HTRANS = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
            HWRITE = w;
        end else begin
            HWRITE = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 3);
            case (n)
                0: begin HSEL = 1'b0; HTRANS = 2'b10; end
                1: begin HSEL = 1'b1; HTRANS = 2'b00; end
                2: begin HSEL = 1'b1; HTRANS = 2'b01; end
                default: begin
                    HSEL   = !dp_valid;
                    HTRANS = 2'b10;
                    HREADY = dp_valid;
                end
            endcase
        end
        e.led   = m_led;
        e.tick  = m_tick;
        e.rd    = dp_valid && !dp_write;
        e.rdata = model_read(dp_idx);
        exp_q.push_back(e);
        model_advance();
        dp_valid = v;
        dp_write = w;
        dp_idx   = idx;
        dp_wdata = wd;
    endtask

    task automatic do_reset();
        exp_t e;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b0;
        bus_idle();
        model_reset();
        dp_valid = 1'b0;
        dp_write = 1'b0;
        dp_idx   = 2'd0;
        dp_wdata = 32'd0;
        e.led   = 8'h01;
        e.tick  = 1'b0;
        e.rd    = 1'b0;
        e.rdata = 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [1:0] idx, input logic [31:0] d);
        step(1'b1, 1'b1, idx, d);
    endtask

    task automatic rd(input logic [1:0] idx);
        step(1'b1, 1'b0, idx, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 32'd0);
    endtask

    always @(negedge HCLK) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (led !== e.led) begin
                errors++;
                $display("FAIL led: got %h expected %h at %0t", led, e.led, $time);
            end
            checks++;
            if (tick !== e.tick) begin
                errors++;
                $display("FAIL tick: got %b expected %b at %0t", tick, e.tick, $time);
            end
            if (e.rd) begin
                checks++;
                if (HRDATA !== e.rdata) begin
                    errors++;
                    $display("FAIL hrdata: got %h expected %h at %0t", HRDATA, e.rdata, $time);
                end
            end
        end
    end

    initial begin
        logic [1:0]  r_idx;
        logic [31:0] r_dat;
        HRESETn = 1'b0;
        HSIZE   = 3'b010;
        HPROT   = 4'b0011;
        bus_idle();
        model_reset();
        dp_valid = 1'b0;
        dp_write = 1'b0;
        dp_idx   = 2'd0;
        dp_wdata = 32'd0;

        // Reset state and register readback.
        do_reset();
        idle(1);
        rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
        idle(1);

        // Rotate left every 4 cycles across a full wrap.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h101);
        idle(40);

        // Rotate right from 0x81, then SEED colliding with every-cycle ticks.
        wr(2'd0, 32'h102);
        wr(2'd2, 32'h81);
        idle(18);
        wr(2'd1, 32'd0);
        idle(3);
        wr(2'd2, 32'h5A);
        idle(3);

        // Blink at full rate.
        wr(2'd0, 32'h103);
        wr(2'd1, 32'd0);
        wr(2'd2, 32'h01);
        idle(8);

        // Back-to-back writes then status reads.
        wr(2'd0, 32'h101);
        wr(2'd1, 32'd5);
        rd(2'd3); rd(2'd0); rd(2'd1);
        idle(3);
        rd(2'd3);
        wr(2'd3, 32'hFFFF);
        rd(2'd3);

        // Disable mid-count, then re-enable.
        wr(2'd1, 32'd3);
        idle(6);
        wr(2'd0, 32'h001);
        idle(5);
        rd(2'd3);
        wr(2'd0, 32'h101);
        idle(10);

        // Asynchronous reset in the middle of activity.
        do_reset();
        idle(2);
        rd(2'd0); rd(2'd1);

        // Randomised traffic.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 9) < 4) begin
                idle(1);
            end else begin
                r_idx = 2'($urandom_range(0, 3));
                case (r_idx)
                    2'd1:    r_dat = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 6));
                    default: r_dat = $urandom();
                endcase
                step(1'b1, 1'($urandom_range(0, 1)), r_idx, r_dat);
            end
        end

        idle(2);
        @(negedge HCLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
